fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  Parametrised fetch stage with an instruction queue. Requests 32-bit words from the instruction cache,
//  buffers up to FIFO_DEPTH {pc, instruction} entries and hands them to decode over a valid/ready handshake.
//  Redirects from the execute-stage branch unit flush the queue and any in-flight fetch.
//  Sits between the instruction cache and the decode stage.
// PARAMETERS
//  XLEN        32   address/instruction width
//  RESET_PC    0    first fetch address after reset
//  FIFO_DEPTH  4    queue entries; power of two, >= 2
// PORTS
//  clk_i                 in   1     clock, rising edge
//  rst_i                 in   1     asynchronous, active-low reset
//  bellek_istek_o        out  1     fetch request to instruction cache
//  bellek_ps_o           out  XLEN  fetch address; stable while bellek_istek_o=1
//  bellek_gecerli_i      in   1     cache response valid; completes the request when bellek_istek_o=1
//  bellek_deger_i        in   XLEN  instruction word returned by cache
//  coz_bos_i             in   1     decode ready to accept
//  coz_buyruk_gecerli_o  out  1     queue head valid
//  coz_buyruk_o          out  XLEN  queue head instruction
//  coz_ps_o              out  XLEN  queue head pc
//  yurut_ps_i            in   XLEN  branch target
//  yurut_ps_gecerli_i    in   1     branch resolved this cycle
//  yurut_atladi_i        in   1     branch taken; redirect only if yurut_ps_gecerli_i=1 as well
// BEHAVIOUR
//  - Reset (rst_i=0, async): state IDLE, fetch pc=RESET_PC, queue empty.
//    Outputs: istek=0, bellek_ps_o=RESET_PC, coz_buyruk_gecerli_o=0, coz_buyruk_o=0, coz_ps_o=0.
//    A cache response arriving after reset is ignored (no request is pending).
//  - FSM IDLE/REQ/DROP.
//    IDLE->REQ when count+pop_free < FIFO_DEPTH.
//    REQ: istek=1, ps=pc, held until gecerli=1. On that edge push {pc, deger}, pc+=4.
//      Stay in REQ if room remains, else IDLE.
//    DROP: istek=1 at old ps until gecerli=1. Response discarded. Then REQ at redirect pc.
//  - Only one request is ever outstanding. The request is never withdrawn once raised.
//  - Decode pop on coz_buyruk_gecerli_o & coz_bos_i. Head outputs hold while not popped.
//  - Full: no new request. Push and pop in the same cycle at full is legal; count is unchanged.
//  - Redirect (yurut_ps_gecerli_i & yurut_atladi_i) takes priority over push and pop:
//    * queue cleared; coz_buyruk_gecerli_o=0 the next cycle; pc<=yurut_ps_i.
//    * REQ with gecerli=0 goes to DROP. REQ with gecerli=1: response dropped, then REQ at target.
//    * Redirect during DROP overwrites the pending target; the latest redirect wins.
//  - yurut_ps_gecerli_i=1 with yurut_atladi_i=0: no effect.
//  - pc arithmetic is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0. yurut_ps_i[1:0] are forced to 0.
//  - Latency without bypass: gecerli edge -> head valid next cycle.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when the queue is empty, decode is ready and a response is accepted,
//    {pc, deger} drive coz_* combinationally in the same cycle and are not pushed (0-cycle latency).
//    No bypass is done during a redirect or in DROP.
//  Undefined: every response goes through the queue (1-cycle latency).
// STRUCTURE
//  - Package fetch_pkg: XLEN, INSN_BYTES=4, getir_durum_t enum {IDLE, REQ, DROP},
//    getir_kayit_t struct {ps, buyruk}.
//  - Sub-module sync_fifo: parametrised width/depth; push, pop, clear, full, empty, count.
//    Async active-low reset; clear has priority over push.
// TESTING
//  1 Reset release, cache answers every cycle, decode always ready -> istek=1 at ps 0,4,8.
//    coz_ps_o 0,4,8 one cycle after each response (bypass off).
//  2 Decode stalled (coz_bos_i=0) with FIFO_DEPTH=4 -> exactly 4 pushes, then istek=0.
//    Head holds ps 0 / word 0x00B8FF11. One pop -> one new request.
//  3 Redirect to 0x0000_0100 while REQ waits 3 cycles for gecerli -> DROP.
//    bellek_ps_o keeps the old address until gecerli; that word never reaches decode.
//    Next request at 0x100.
//  4 Redirect coinciding with gecerli and a decode pop -> queue empty next cycle, response discarded.
//    Next request at target. A not-taken branch (atladi=0) leaves the queue intact.
//  5 RESET_PC=0xFFFF_FFF8 -> fetches at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//    rst_i dropped mid-REQ -> istek=0 immediately; outputs at reset values.
//  6 FETCH_BYPASS_EN defined, empty queue, decode ready -> coz_buyruk_o=bellek_deger_i in the gecerli cycle.
//    Redirect in the same cycle blocks the bypass.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its instruction queue.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } getir_durum_t;

  typedef struct packed {
    logic [XLEN-1:0] ps;
    logic [XLEN-1:0] buyruk;
  } getir_kayit_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count. Clear wins over push and pop.
// Push at full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: one outstanding I-cache request at a time, responses queued
// for decode. Taken branches flush the queue and squash an in-flight fetch
// (DROP waits out the old request before fetching at the target).
// Optional macro FETCH_BYPASS_EN: a response arriving while the queue is
// empty and decode is ready goes straight to decode in the same cycle.
// XLEN is expected to match fetch_pkg::XLEN (queue entry layout).
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN       = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            bellek_istek_o,
  output logic [XLEN-1:0] bellek_ps_o,
  input  logic            bellek_gecerli_i,
  input  logic [XLEN-1:0] bellek_deger_i,
  input  logic            coz_bos_i,
  output logic            coz_buyruk_gecerli_o,
  output logic [XLEN-1:0] coz_buyruk_o,
  output logic [XLEN-1:0] coz_ps_o,
  input  logic [XLEN-1:0] yurut_ps_i,
  input  logic            yurut_ps_gecerli_i,
  input  logic            yurut_atladi_i
);

  localparam int              CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int              SW   = CW + 1;
  localparam logic [XLEN-1:0] ADIM = XLEN'(INSN_BYTES);

  getir_durum_t    durum_q, durum_d;
  logic [XLEN-1:0] ps_q, ps_d;
  logic [XLEN-1:0] eski_ps_q, eski_ps_d;
  logic [XLEN-1:0] hedef;
  logic            yonlendir, yanit, atla, itme, cekme, oda;
  logic            fifo_dolu, fifo_bos;
  logic [CW-1:0]   fifo_sayi;
  logic [SW-1:0]   sayi_sonra;
  getir_kayit_t    giris_kayit, bas_kayit;

  assign yonlendir = yurut_ps_gecerli_i & yurut_atladi_i;
  assign hedef     = {yurut_ps_i[XLEN-1:2], 2'b00};
  assign yanit     = (durum_q == REQ) & bellek_gecerli_i;

`ifdef FETCH_BYPASS_EN
  assign atla = yanit & fifo_bos & coz_bos_i & ~yonlendir;
`else
  assign atla = 1'b0;
`endif

  assign itme  = yanit & ~yonlendir & ~atla;
  assign cekme = ~fifo_bos & coz_bos_i & ~yonlendir;

  // Room after this cycle's push/pop decides whether to keep requesting.
  assign sayi_sonra = {1'b0, fifo_sayi} + SW'(itme) - SW'(cekme);
  assign oda = (durum_q == REQ) ? (sayi_sonra < SW'(FIFO_DEPTH)) : (~fifo_dolu | cekme);

  assign giris_kayit = '{ps: ps_q, buyruk: bellek_deger_i};

  sync_fifo #(
    .WIDTH($bits(getir_kayit_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_kuyruk (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .push_i (itme),
    .data_i (giris_kayit),
    .pop_i  (cekme),
    .clear_i(yonlendir),
    .data_o (bas_kayit),
    .full_o (fifo_dolu),
    .empty_o(fifo_bos),
    .count_o(fifo_sayi)
  );

  // Fetch FSM state, next fetch pc and the address of a squashed request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q   <= IDLE;
      ps_q      <= RESET_PC;
      eski_ps_q <= RESET_PC;
    end else begin
      durum_q   <= durum_d;
      ps_q      <= ps_d;
      eski_ps_q <= eski_ps_d;
    end
  end

  // Next-state logic; a taken branch overrides the normal transitions.
  always_comb begin
    durum_d   = durum_q;
    ps_d      = ps_q;
    eski_ps_d = eski_ps_q;
    unique case (durum_q)
      IDLE: if (oda) durum_d = REQ;
      REQ: begin
        if (bellek_gecerli_i) begin
          ps_d    = ps_q + ADIM;
          durum_d = oda ? REQ : IDLE;
        end
      end
      DROP:    if (bellek_gecerli_i) durum_d = REQ;
      default: durum_d = IDLE;
    endcase
    if (yonlendir) begin
      ps_d = hedef;
      if (durum_q == REQ && !bellek_gecerli_i) begin
        durum_d   = DROP;
        eski_ps_d = ps_q;
      end else if (durum_q == DROP && !bellek_gecerli_i) begin
        durum_d = DROP;
      end else begin
        durum_d = REQ;
      end
    end
  end

  assign bellek_istek_o = (durum_q != IDLE);
  assign bellek_ps_o    = (durum_q == DROP) ? eski_ps_q : ps_q;

  // Decode-side view: queue head, zeroed when empty, or the bypassed response.
  always_comb begin
    coz_buyruk_gecerli_o = ~fifo_bos;
    coz_ps_o             = fifo_bos ? '0 : bas_kayit.ps;
    coz_buyruk_o         = fifo_bos ? '0 : bas_kayit.buyruk;
    if (atla) begin
      coz_buyruk_gecerli_o = 1'b1;
      coz_ps_o             = ps_q;
      coz_buyruk_o         = bellek_deger_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: a cycle table for streaming and
// redirect behaviour, plus hand sequences for stall, DROP, pc wrap, async
// reset and (with FETCH_BYPASS_EN) the zero-latency bypass.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gecerli, bos, yv, ya;
  logic [31:0] deger, yp;
  logic        istek, cv, istek2, cv2;
  logic [31:0] ps, cb, cps, ps2, cb2, cps2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue_stage #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .bellek_istek_o(istek), .bellek_ps_o(ps),
    .bellek_gecerli_i(gecerli), .bellek_deger_i(deger),
    .coz_bos_i(bos), .coz_buyruk_gecerli_o(cv), .coz_buyruk_o(cb), .coz_ps_o(cps),
    .yurut_ps_i(yp), .yurut_ps_gecerli_i(yv), .yurut_atladi_i(ya)
  );

  fetch_queue_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
    .clk_i(clk), .rst_i(rst_n),
    .bellek_istek_o(istek2), .bellek_ps_o(ps2),
    .bellek_gecerli_i(gecerli), .bellek_deger_i(deger),
    .coz_bos_i(bos), .coz_buyruk_gecerli_o(cv2), .coz_buyruk_o(cb2), .coz_ps_o(cps2),
    .yurut_ps_i(yp), .yurut_ps_gecerli_i(yv), .yurut_atladi_i(ya)
  );

  typedef struct {
    logic        g;
    logic [31:0] d;
    logic        b;
    logic        yv;
    logic        ya;
    logic [31:0] yp;
    logic        e_istek;
    logic [31:0] e_ps;
    logic        e_cv;
    logic [31:0] e_cps;
    logic [31:0] e_cb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic [31:0] d, input logic b,
                       input logic v, input logic a, input logic [31:0] p);
    gecerli = g; deger = d; bos = b; yv = v; ya = a; yp = p;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, release just after a rising edge: the next cycle is IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

`ifndef FETCH_BYPASS_EN
  vec_t tbl [12];
`endif

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset values on both instances.
    @(negedge clk);
    chk("rst istek", 32'(istek), 32'd0);
    chk("rst ps", ps, 32'h0);
    chk("rst cv", 32'(cv), 32'd0);
    chk("rst cb", cb, 32'h0);
    chk("rst cps", cps, 32'h0);
    chk("rst2 istek", 32'(istek2), 32'd0);
    chk("rst2 ps", ps2, 32'hFFFF_FFF8);
    chk("rst2 cv", 32'(cv2), 32'd0);

`ifndef FETCH_BYPASS_EN
    // Streaming with one-cycle queue latency, taken redirect with a
    // simultaneous response and pop, then a not-taken branch.
    //           g  d             b  yv ya yp            istek ps           cv cps          cb
    tbl[0]  = '{1, 32'h0BAD_0000, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0};
    tbl[1]  = '{1, 32'hA000_0000, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0};
    tbl[2]  = '{1, 32'hA000_0001, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'hA000_0000};
    tbl[3]  = '{1, 32'hA000_0002, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'hA000_0001};
    tbl[4]  = '{1, 32'hA000_0003, 1, 0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'hA000_0002};
    tbl[5]  = '{1, 32'hA000_0004, 1, 1, 1, 32'h0000_0203, 1, 32'h10,      1, 32'hC,        32'hA000_0003};
    tbl[6]  = '{0, 32'h0,         1, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h0};
    tbl[7]  = '{1, 32'hB000_0000, 1, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h0};
    tbl[8]  = '{1, 32'hB000_0001, 0, 1, 0, 32'h400,      1, 32'h204,      1, 32'h200,      32'hB000_0000};
    tbl[9]  = '{0, 32'h0,         1, 0, 0, 32'h0,        1, 32'h208,      1, 32'h200,      32'hB000_0000};
    tbl[10] = '{0, 32'h0,         1, 0, 0, 32'h0,        1, 32'h208,      1, 32'h204,      32'hB000_0001};
    tbl[11] = '{0, 32'h0,         1, 0, 0, 32'h0,        1, 32'h208,      0, 32'h0,        32'h0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].g, tbl[i].d, tbl[i].b, tbl[i].yv, tbl[i].ya, tbl[i].yp);
      @(negedge clk);
      chk($sformatf("tbl[%0d] istek", i), 32'(istek), 32'(tbl[i].e_istek));
      chk($sformatf("tbl[%0d] ps", i), ps, tbl[i].e_ps);
      chk($sformatf("tbl[%0d] cv", i), 32'(cv), 32'(tbl[i].e_cv));
      chk($sformatf("tbl[%0d] cps", i), cps, tbl[i].e_cps);
      chk($sformatf("tbl[%0d] cb", i), cb, tbl[i].e_cb);
      next_cycle();
    end
`endif

    // Decode stalled: four pushes fill the queue, then requests stop.
    do_reset();
    drive(1, 32'h0, 0, 0, 0, 0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      deger = (i == 0) ? 32'h00B8_FF11 : 32'h0000_0022 * 32'(i);
      @(negedge clk);
      chk($sformatf("fill%0d istek", i), 32'(istek), 32'd1);
      chk($sformatf("fill%0d ps", i), ps, 32'(4 * i));
      next_cycle();
    end
    gecerli = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("full%0d istek", i), 32'(istek), 32'd0);
      chk($sformatf("full%0d cps", i), cps, 32'h0);
      chk($sformatf("full%0d cb", i), cb, 32'h00B8_FF11);
      next_cycle();
    end
    bos = 1'b1;
    @(negedge clk);
    chk("pop istek", 32'(istek), 32'd0);
    chk("pop cv", 32'(cv), 32'd1);
    next_cycle();
    bos = 1'b0;
    @(negedge clk);
    chk("refill istek", 32'(istek), 32'd1);
    chk("refill ps", ps, 32'h10);
    chk("refill cps", cps, 32'h4);
    chk("refill cb", cb, 32'h22);
    next_cycle();
    @(negedge clk);
    chk("refill hold ps", ps, 32'h10);
    next_cycle();

    // Redirect while waiting on the cache: DROP keeps the old address,
    // a second redirect during DROP replaces the target.
    do_reset();
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin yv = 1'b1; ya = 1'b1; yp = 32'h0000_0100; end
      @(negedge clk);
      chk($sformatf("wait%0d ps", i), ps, 32'h0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drop istek", 32'(istek), 32'd1);
    chk("drop ps", ps, 32'h0);
    chk("drop cv", 32'(cv), 32'd0);
    next_cycle();
    drive(0, 0, 0, 1, 1, 32'h0000_0302);
    @(negedge clk);
    chk("drop redir ps", ps, 32'h0);
    next_cycle();
    drive(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    @(negedge clk);
    chk("drop resp ps", ps, 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("after drop istek", 32'(istek), 32'd1);
    chk("after drop ps", ps, 32'h300);
    chk("after drop cv", 32'(cv), 32'd0);
    next_cycle();
    drive(1, 32'h1234_5678, 0, 0, 0, 0);
    @(negedge clk);
    chk("target fetch ps", ps, 32'h300);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("target head cv", 32'(cv), 32'd1);
    chk("target head cps", cps, 32'h300);
    chk("target head cb", cb, 32'h1234_5678);
    chk("target next ps", ps, 32'h304);
    next_cycle();

    // PC wrap on the second instance, then async reset mid-request.
    do_reset();
    drive(1, 32'h5555_0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap idle ps", ps2, 32'hFFFF_FFF8);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("wrap%0d istek", i), 32'(istek2), 32'd1);
      chk($sformatf("wrap%0d ps", i), ps2, 32'hFFFF_FFF8 + 32'(4 * i));
      next_cycle();
    end
    chk("pre-rst cv2", 32'(cv2), 32'd1);
    chk("pre-rst cps2", cps2, 32'hFFFF_FFF8);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst istek2", 32'(istek2), 32'd0);
    chk("async rst ps2", ps2, 32'hFFFF_FFF8);
    chk("async rst cv2", 32'(cv2), 32'd0);
    chk("async rst cps2", cps2, 32'h0);
    chk("async rst cb2", cb2, 32'h0);
    chk("async rst istek", 32'(istek), 32'd0);
    next_cycle();

`ifdef FETCH_BYPASS_EN
    // Bypass: empty queue and ready decode see the response in the same cycle;
    // a simultaneous redirect suppresses it.
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    next_cycle();
    drive(1, 32'hCAFE_0001, 1, 0, 0, 0);
    @(negedge clk);
    chk("byp cv", 32'(cv), 32'd1);
    chk("byp cps", cps, 32'h0);
    chk("byp cb", cb, 32'hCAFE_0001);
    next_cycle();
    drive(1, 32'hCAFE_0002, 1, 1, 1, 32'h40);
    @(negedge clk);
    chk("byp redir cv", 32'(cv), 32'd0);
    chk("byp redir ps", ps, 32'h4);
    next_cycle();
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("byp target ps", ps, 32'h40);
    chk("byp target cv", 32'(cv), 32'd0);
    next_cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
